// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: sequences one decoded op at a time into the execution unit.
// It latches the operand bundle from decode, fires a one-cycle start pulse,
// waits for the EXU finish strobe, selects the class result and holds it for
// writeback. Flush and a wait watchdog recover from killed or hung ops.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready        decode handshake (ready only in IDLE)
//   in_aluop..in_wen         decoded op bundle
//   exu_valid, exu_*         start pulse and latched operands to the EXU
//   exu_finish, *_out        EXU result strobe and result buses
//   redirect_valid_out       EXU branch-taken flag
//   flush                    kill the in-flight op
//   out_valid/out_ready      writeback handshake
//   out_data/out_rd/out_wen/out_redirect   writeback payload
//   busy, timeout_err        status (timeout_err is sticky until reset)
//
// state | meaning
// IDLE  | ready for a new op
// ISSUE | start pulse to the EXU this cycle
// WAIT  | waiting for exu_finish, watchdog running
// DONE  | result held for writeback
// DRAIN | op killed, swallowing the EXU finish, watchdog running
module exu_issue_ctrl #(
  parameter int ALUOP_W = 5,
  parameter int BRSEL_W = 3,
  parameter int TIMEOUT = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [BRSEL_W-1:0] in_brsel,
  input  logic [63:0]        in_a,
  input  logic [63:0]        in_b,
  input  logic [63:0]        in_rs1,
  input  logic [63:0]        in_rs2,
  input  logic [63:0]        in_pc,
  input  logic [63:0]        in_imm,
  input  logic [4:0]         in_rd,
  input  logic               in_wen,
  output logic               exu_valid,
  output logic [ALUOP_W-1:0] exu_aluop,
  output logic [BRSEL_W-1:0] exu_brsel,
  output logic [63:0]        exu_a,
  output logic [63:0]        exu_b,
  output logic [63:0]        exu_rs1,
  output logic [63:0]        exu_rs2,
  output logic [63:0]        exu_pc,
  output logic [63:0]        exu_imm,
  input  logic               exu_finish,
  input  logic [63:0]        alu_out,
  input  logic [63:0]        br_out,
  input  logic [63:0]        div_out,
  input  logic [63:0]        rem_out,
  input  logic [63:0]        mul_out,
  input  logic               redirect_valid_out,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic [4:0]         out_rd,
  output logic               out_wen,
  output logic               out_redirect,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] TRIP = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        wen_q;
  logic        is_div, is_mul, is_br;
  logic        wd_trip, accept, capture, wd_fire;
  logic [63:0] result;

  // Class decode from the latched opcode; div > mul > branch > ALU.
  assign is_div = (exu_aluop >= ALUOP_W'(17)) && (exu_aluop <= ALUOP_W'(24));
  assign is_mul = (exu_aluop == ALUOP_W'(15)) || (exu_aluop == ALUOP_W'(16));
  assign is_br  = (exu_brsel != '0) && !is_div && !is_mul;

  always_comb begin
    result = alu_out;
    if (is_div)      result = exu_aluop[0] ? div_out : rem_out;
    else if (is_mul) result = mul_out;
    else if (is_br)  result = br_out;
  end

  // Counter holds the number of completed wait cycles, so the TIMEOUT-th
  // wait cycle sees TIMEOUT-1. >= keeps a flush-late DRAIN from slipping past.
  assign wd_trip = (wait_cnt >= TRIP);
  assign accept  = (state == S_IDLE) && in_valid && !flush;
  assign capture = (state == S_WAIT) && exu_finish && !flush;
  assign wd_fire = wd_trip && !exu_finish &&
                   (((state == S_WAIT) && !flush) || (state == S_DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush && exu_finish) state_nxt = S_IDLE;
        else if (flush)          state_nxt = S_DRAIN;
        else if (exu_finish)     state_nxt = S_DONE;
        else if (wd_trip)        state_nxt = S_IDLE;
      end
      S_DONE:  if (flush || out_ready) state_nxt = S_IDLE;
      S_DRAIN: if (exu_finish || wd_trip) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    exu_valid = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:  begin in_ready = 1'b1; busy = 1'b0; end
      S_ISSUE: exu_valid = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exu_aluop    <= '0;
      exu_brsel    <= '0;
      exu_a        <= '0;
      exu_b        <= '0;
      exu_rs1      <= '0;
      exu_rs2      <= '0;
      exu_pc       <= '0;
      exu_imm      <= '0;
      out_rd       <= '0;
      wen_q        <= 1'b0;
      out_data     <= '0;
      out_wen      <= 1'b0;
      out_redirect <= 1'b0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (accept) begin
        exu_aluop <= in_aluop;
        exu_brsel <= in_brsel;
        exu_a     <= in_a;
        exu_b     <= in_b;
        exu_rs1   <= in_rs1;
        exu_rs2   <= in_rs2;
        exu_pc    <= in_pc;
        exu_imm   <= in_imm;
        out_rd    <= in_rd;
        wen_q     <= in_wen;
      end
      if (capture) begin
        out_data     <= result;
        out_wen      <= wen_q;
        out_redirect <= redirect_valid_out && is_br;
      end
      if (wd_fire) timeout_err <= 1'b1;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if ((state == S_WAIT) || (state == S_DRAIN))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Bench for exu_issue_ctrl: table of op vectors, hand sequences for flush,
// backpressure, watchdog and reset, then random ops against a class model.
// A second instance with a short watchdog covers the timeout path.
module tb_exu_issue_ctrl;
  localparam int WD_TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready, exu_finish, redirect_valid_out, in_wen;
  logic [4:0]  in_aluop, in_rd;
  logic [2:0]  in_brsel;
  logic [63:0] in_a, in_b, in_rs1, in_rs2, in_pc, in_imm;
  logic [63:0] alu_out, br_out, div_out, rem_out, mul_out;

  logic        in_ready, exu_valid, out_valid, out_wen, out_redirect, busy, timeout_err;
  logic [4:0]  exu_aluop, out_rd;
  logic [2:0]  exu_brsel;
  logic [63:0] exu_a, exu_b, exu_rs1, exu_rs2, exu_pc, exu_imm, out_data;

  logic        w_in_ready, w_exu_valid, w_out_valid, w_out_wen, w_out_redirect, w_busy, w_timeout_err;
  logic [4:0]  w_exu_aluop, w_out_rd;
  logic [2:0]  w_exu_brsel;
  logic [63:0] w_exu_a, w_exu_b, w_exu_rs1, w_exu_rs2, w_exu_pc, w_exu_imm, w_out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_issue_ctrl #(.ALUOP_W(5), .BRSEL_W(3), .TIMEOUT(127)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_brsel(in_brsel), .in_a(in_a), .in_b(in_b),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen), .exu_valid(exu_valid),
    .exu_aluop(exu_aluop), .exu_brsel(exu_brsel), .exu_a(exu_a), .exu_b(exu_b),
    .exu_rs1(exu_rs1), .exu_rs2(exu_rs2), .exu_pc(exu_pc), .exu_imm(exu_imm),
    .exu_finish(exu_finish), .alu_out(alu_out), .br_out(br_out),
    .div_out(div_out), .rem_out(rem_out), .mul_out(mul_out),
    .redirect_valid_out(redirect_valid_out), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_redirect(out_redirect),
    .busy(busy), .timeout_err(timeout_err)
  );

  exu_issue_ctrl #(.ALUOP_W(5), .BRSEL_W(3), .TIMEOUT(WD_TIMEOUT)) dut_wd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_aluop(in_aluop), .in_brsel(in_brsel), .in_a(in_a), .in_b(in_b),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen), .exu_valid(w_exu_valid),
    .exu_aluop(w_exu_aluop), .exu_brsel(w_exu_brsel), .exu_a(w_exu_a), .exu_b(w_exu_b),
    .exu_rs1(w_exu_rs1), .exu_rs2(w_exu_rs2), .exu_pc(w_exu_pc), .exu_imm(w_exu_imm),
    .exu_finish(exu_finish), .alu_out(alu_out), .br_out(br_out),
    .div_out(div_out), .rem_out(rem_out), .mul_out(mul_out),
    .redirect_valid_out(redirect_valid_out), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_rd(w_out_rd), .out_wen(w_out_wen), .out_redirect(w_out_redirect),
    .busy(w_busy), .timeout_err(w_timeout_err)
  );

  typedef struct {
    logic [4:0]  aluop;
    logic [2:0]  brsel;
    logic        redir;
    logic [63:0] a, b;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] r_alu, r_br, r_div, r_rem, r_mul;
    logic [63:0] exp_data;
    logic        exp_redir;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_results(input logic [63:0] ra, input logic [63:0] rb, input logic [63:0] rd_,
                             input logic [63:0] rr, input logic [63:0] rm, input logic rv);
    alu_out = ra; br_out = rb; div_out = rd_; rem_out = rr; mul_out = rm;
    redirect_valid_out = rv;
  endtask

  // Present one op, check the start pulse and latched operands, end in the
  // first WAIT cycle.
  task automatic drive_op(input logic [4:0] aluop, input logic [2:0] brsel, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic wen);
    logic [63:0] pc, imm;
    pc = {$urandom(), $urandom()};
    imm = {$urandom(), $urandom()};
    chk("op_in_ready", 64'(in_ready), 64'd1);
    in_aluop = aluop; in_brsel = brsel; in_a = a; in_b = b; in_rs1 = a; in_rs2 = b;
    in_pc = pc; in_imm = imm; in_rd = rd; in_wen = wen; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("issue_pulse", 64'(exu_valid), 64'd1);
    chk("issue_aluop", 64'(exu_aluop), 64'(aluop));
    chk("issue_brsel", 64'(exu_brsel), 64'(brsel));
    chk("issue_a", exu_a, a);
    chk("issue_b", exu_b, b);
    chk("issue_rs1", exu_rs1, a);
    chk("issue_pc", exu_pc, pc);
    chk("issue_imm", exu_imm, imm);
    tick();
    chk("wait_pulse_low", 64'(exu_valid), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  // Sit in WAIT for lat more cycles, then strobe finish; ends in DONE.
  task automatic finish_after(input int lat, input logic [63:0] a);
    int bad = 0;
    for (int j = 0; j < lat; j++) begin
      tick();
      if (busy !== 1'b1 || out_valid !== 1'b0 || exu_valid !== 1'b0 || exu_a !== a) bad++;
    end
    chk("wait_hold", 64'(bad), 64'd0);
    exu_finish = 1'b1;
    tick();
    exu_finish = 1'b0;
    chk("done_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic retire(input int stall, input logic [63:0] data, input logic redir,
                        input logic [4:0] rd, input logic wen);
    int bad = 0;
    chk("out_data", out_data, data);
    chk("out_redirect", 64'(out_redirect), 64'(redir));
    chk("out_rd", 64'(out_rd), 64'(rd));
    chk("out_wen", 64'(out_wen), 64'(wen));
    out_ready = 1'b0;
    for (int j = 0; j < stall; j++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== data || out_rd !== rd || in_ready !== 1'b0) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_in_ready", 64'(in_ready), 64'd1);
    chk("ret_out_valid", 64'(out_valid), 64'd0);
  endtask

  // Reference: result class from the opcode rules. Returns {redirect, data}.
  function automatic logic [64:0] model(input int aluop, input int brsel, input logic redir,
                                        input logic [63:0] ra, input logic [63:0] rb,
                                        input logic [63:0] rd_, input logic [63:0] rr,
                                        input logic [63:0] rm);
    if (aluop >= 17 && aluop <= 24) return {1'b0, (aluop % 2 == 0) ? rr : rd_};
    if (aluop == 15 || aluop == 16) return {1'b0, rm};
    if (brsel != 0)                 return {redir, rb};
    return {1'b0, ra};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    vecs[0]  = '{5'd0,  3'd0, 1'b0, 64'd5,   64'd7, 5'd3,  1'b1, 64'd12,  64'hAA, 64'hBB, 64'hCC, 64'hDD, 64'd12,  1'b0};
    vecs[1]  = '{5'd17, 3'd0, 1'b0, 64'd100, 64'd7, 5'd4,  1'b1, 64'd111, 64'd222, 64'd14, 64'd2, 64'd333, 64'd14, 1'b0};
    vecs[2]  = '{5'd18, 3'd0, 1'b0, 64'd100, 64'd7, 5'd5,  1'b1, 64'd111, 64'd222, 64'd14, 64'd2, 64'd333, 64'd2,  1'b0};
    vecs[3]  = '{5'd15, 3'd0, 1'b0, 64'd6,   64'd7, 5'd6,  1'b1, 64'd1, 64'd2, 64'd3, 64'd4, 64'd42, 64'd42, 1'b0};
    vecs[4]  = '{5'd16, 3'd0, 1'b0, 64'd9,   64'd9, 5'd7,  1'b0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd77, 64'd77, 1'b0};
    vecs[5]  = '{5'd0,  3'd1, 1'b1, 64'd1,   64'd2, 5'd8,  1'b1, 64'd9, 64'h80, 64'd3, 64'd4, 64'd5, 64'h80, 1'b1};
    vecs[6]  = '{5'd0,  3'd2, 1'b0, 64'd1,   64'd2, 5'd9,  1'b0, 64'd9, 64'h81, 64'd3, 64'd4, 64'd5, 64'h81, 1'b0};
    vecs[7]  = '{5'd24, 3'd1, 1'b1, 64'd1,   64'd2, 5'd10, 1'b1, 64'd9, 64'h82, 64'd3, 64'd4, 64'd5, 64'd4,  1'b0};
    vecs[8]  = '{5'd23, 3'd5, 1'b1, 64'd1,   64'd2, 5'd11, 1'b1, 64'd9, 64'h83, 64'd3, 64'd4, 64'd5, 64'd3,  1'b0};
    vecs[9]  = '{5'd25, 3'd0, 1'b1, 64'd1,   64'd2, 5'd12, 1'b1, 64'd9, 64'h84, 64'd3, 64'd4, 64'd5, 64'd9,  1'b0};
    vecs[10] = '{5'd14, 3'd0, 1'b0, 64'd1,   64'd2, 5'd13, 1'b1, 64'd10, 64'h85, 64'd3, 64'd4, 64'd5, 64'd10, 1'b0};
    vecs[11] = '{5'd16, 3'd3, 1'b1, 64'd1,   64'd2, 5'd14, 1'b1, 64'd10, 64'h86, 64'd3, 64'd4, 64'd55, 64'd55, 1'b0};
    vecs[12] = '{5'd0,  3'd0, 1'b1, 64'd1,   64'd2, 5'd31, 1'b1, 64'd11, 64'h87, 64'd3, 64'd4, 64'd5, 64'd11, 1'b0};

    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; exu_finish = 1'b0;
    redirect_valid_out = 1'b0; in_wen = 1'b0; in_aluop = '0; in_rd = '0; in_brsel = '0;
    in_a = '0; in_b = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
    set_results(64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_exu_valid", 64'(exu_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_exu_a", exu_a, 64'd0);
    chk("rst_wd_zero", 64'(|{w_exu_aluop, w_exu_brsel, w_exu_a, w_exu_b, w_exu_rs1, w_exu_rs2,
                             w_exu_pc, w_exu_imm, w_out_data, w_out_rd, w_out_valid, w_exu_valid,
                             w_out_wen, w_out_redirect, w_busy, w_timeout_err}), 64'd0);
    rst = 1'b1;
    tick();

    // table of single ops, varying EXU latency and writeback stall
    for (int i = 0; i < 13; i++) begin
      set_results(vecs[i].r_alu, vecs[i].r_br, vecs[i].r_div, vecs[i].r_rem, vecs[i].r_mul, vecs[i].redir);
      drive_op(vecs[i].aluop, vecs[i].brsel, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wen);
      finish_after(i % 3, vecs[i].a);
      retire(i % 2, vecs[i].exp_data, vecs[i].exp_redir, vecs[i].rd, vecs[i].wen);
    end

    // long divide stall: busy throughout
    set_results(64'd1, 64'd2, 64'd14, 64'd2, 64'd3, 1'b0);
    drive_op(5'd17, 3'd0, 64'd100, 64'd7, 5'd20, 1'b1);
    finish_after(66, 64'd100);
    retire(0, 64'd14, 1'b0, 5'd20, 1'b1);

    // backpressure with decode pushing a new op
    set_results(64'h55, 64'd2, 64'd3, 64'd4, 64'd5, 1'b0);
    drive_op(5'd0, 3'd0, 64'h1111, 64'h2222, 5'd21, 1'b1);
    finish_after(1, 64'h1111);
    in_valid = 1'b1; in_a = 64'hBAD0BAD0; in_aluop = 5'd15;
    retire(5, 64'h55, 1'b0, 5'd21, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_accept_busy", 64'(busy), 64'd0);
    chk("bp_no_accept_a", exu_a, 64'h1111);

    // op offered with flush in IDLE is dropped
    in_valid = 1'b1; flush = 1'b1; in_a = 64'h77;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'd0);
    chk("idle_flush_a", exu_a, 64'h1111);

    // finish in IDLE ignored
    exu_finish = 1'b1;
    tick();
    exu_finish = 1'b0;
    chk("idle_finish_ov", 64'(out_valid), 64'd0);
    chk("idle_finish_busy", 64'(busy), 64'd0);

    // flush during a 64-cycle multiply: drained, next op gets its own result
    begin
      int bad = 0;
      set_results(64'd0, 64'd0, 64'd0, 64'd0, 64'hDEAD, 1'b0);
      drive_op(5'd15, 3'd0, 64'd3, 64'd4, 5'd22, 1'b1);
      for (int j = 0; j < 10; j++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int j = 0; j < 53; j++) begin
        if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
        tick();
      end
      chk("drain_hold", 64'(bad), 64'd0);
      exu_finish = 1'b1;
      tick();
      exu_finish = 1'b0;
      chk("drain_exit_ov", 64'(out_valid), 64'd0);
      chk("drain_exit_idle", 64'(in_ready), 64'd1);
      set_results(64'h1234, 64'd0, 64'd0, 64'd0, 64'hDEAD, 1'b0);
      drive_op(5'd0, 3'd0, 64'd1, 64'd2, 5'd23, 1'b1);
      finish_after(2, 64'd1);
      retire(0, 64'h1234, 1'b0, 5'd23, 1'b1);
    end

    // flush in ISSUE: pulse still out, then drain
    drive_op(5'd0, 3'd0, 64'd8, 64'd9, 5'd1, 1'b1);
    exu_finish = 1'b0;
    tick(); tick();
    exu_finish = 1'b1;
    tick();
    exu_finish = 1'b0;
    chk("pre_flush_done", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_idle", 64'(in_ready), 64'd1);
    chk("done_flush_ov", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_aluop = 5'd0; in_brsel = 3'd0; in_a = 64'd4;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    chk("issue_flush_pulse", 64'(exu_valid), 64'd1);
    tick();
    flush = 1'b0;
    chk("issue_flush_drain", 64'(busy), 64'd1);
    exu_finish = 1'b1;
    tick();
    exu_finish = 1'b0;
    chk("issue_flush_idle", 64'(busy), 64'd0);
    chk("issue_flush_ov", 64'(out_valid), 64'd0);

    // flush and finish together in WAIT
    drive_op(5'd17, 3'd0, 64'd50, 64'd5, 5'd2, 1'b1);
    flush = 1'b1; exu_finish = 1'b1;
    tick();
    flush = 1'b0; exu_finish = 1'b0;
    chk("ff_idle", 64'(in_ready), 64'd1);
    chk("ff_ov", 64'(out_valid), 64'd0);

    // random ops against the class model
    for (int n = 0; n < 40; n++) begin
      int aluop, brsel, lat, stall, fat;
      logic redir, wen, do_flush;
      logic [4:0] rd;
      logic [63:0] ra, rb, rdv, rr, rm, a;
      logic [64:0] exp;
      int bad;
      aluop = $urandom_range(0, 31);
      brsel = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      redir = 1'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      lat = $urandom_range(0, 12);
      stall = $urandom_range(0, 3);
      do_flush = ($urandom_range(0, 4) == 0);
      fat = $urandom_range(0, lat);
      ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()};
      rdv = {$urandom(), $urandom()}; rr = {$urandom(), $urandom()};
      rm = {$urandom(), $urandom()}; a = {$urandom(), $urandom()};
      exp = model(aluop, brsel, redir, ra, rb, rdv, rr, rm);
      set_results(ra, rb, rdv, rr, rm, redir);
      drive_op(5'(aluop), 3'(brsel), a, {$urandom(), $urandom()}, rd, wen);
      bad = 0;
      for (int j = 0; j <= lat; j++) begin
        if (j == lat) exu_finish = 1'b1;
        if (do_flush && j == fat) flush = 1'b1;
        tick();
        exu_finish = 1'b0; flush = 1'b0;
        if (j < lat && (out_valid !== 1'b0 || busy !== 1'b1)) bad++;
      end
      chk("rnd_wait", 64'(bad), 64'd0);
      if (do_flush) begin
        chk("rnd_flush_ov", 64'(out_valid), 64'd0);
        chk("rnd_flush_idle", 64'(busy), 64'd0);
      end else begin
        chk("rnd_out_valid", 64'(out_valid), 64'd1);
        retire(stall, exp[63:0], exp[64], rd, wen);
      end
    end

    // watchdog on the short-timeout instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("wd_pre_err", 64'(w_timeout_err), 64'd0);
    drive_op(5'd19, 3'd0, 64'd1, 64'd1, 5'd3, 1'b1);
    begin
      int wait_cycles = 1;
      int bad = 0;
      while (wait_cycles < WD_TIMEOUT) begin
        if (w_timeout_err !== 1'b0 || w_busy !== 1'b1) bad++;
        tick();
        wait_cycles++;
      end
      chk("wd_before_trip", 64'(bad), 64'd0);
      chk("wd_last_wait_err", 64'(w_timeout_err), 64'd0);
      chk("wd_last_wait_busy", 64'(w_busy), 64'd1);
      tick();
      chk("wd_trip_err", 64'(w_timeout_err), 64'd1);
      chk("wd_trip_idle", 64'(w_in_ready), 64'd1);
      chk("wd_trip_ov", 64'(w_out_valid), 64'd0);
      tick(); tick(); tick();
      chk("wd_sticky", 64'(w_timeout_err), 64'd1);
      chk("main_no_trip", 64'(timeout_err), 64'd0);
      chk("main_still_wait", 64'(busy), 64'd1);
    end

    // async reset mid-WAIT
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_exu_valid", 64'(exu_valid), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_operands", 64'(|{exu_aluop, exu_brsel, exu_a, exu_b, exu_rs1, exu_rs2, exu_pc, exu_imm}), 64'd0);
    chk("arst_out_flags", 64'({out_wen, out_redirect, timeout_err}), 64'd0);
    chk("arst_wd_err", 64'(w_timeout_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    exu_finish = 1'b1;
    tick();
    exu_finish = 1'b0;
    chk("post_rst_finish_ov", 64'(out_valid), 64'd0);
    chk("post_rst_finish_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
